// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: LSD-first digit-serial adder/subtractor with one cycle of latency.
// A word is open from its first valid digit until the digit with last=1, or until MAX_DIGITS digits if last never comes.
module digit_serial_addsub #(
   parameter int DIGIT_W    = 4,
   parameter int MAX_DIGITS = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               last,
   input  logic               sub,
   output logic               out_vld,
   output logic [DIGIT_W-1:0] sum,
   output logic               out_last,
   output logic               out_cout,
   output logic               out_ovf,
   output logic               len_err
);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t             state_q, state_d;
   logic               carry_q, carry_d, mode_q, mode_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               out_vld_q, out_vld_d, out_last_q, out_last_d;
   logic               out_cout_q, out_cout_d, out_ovf_q, out_ovf_d, len_err_q, len_err_d;
   logic [DIGIT_W-1:0] sum_q, sum_d, bx, s;
   logic               mode, cin, c, cm, forced, close;
   always_comb begin
      mode       = (state_q == IDLE) ? sub : mode_q;
      cin        = (state_q == IDLE) ? sub : carry_q;
      bx         = mode ? ~b : b;
      {c, s}     = {1'b0, a} + {1'b0, bx} + (DIGIT_W+1)'(cin);
      // carry into the top bit, recovered from the top bit's own sum
      cm         = s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ bx[DIGIT_W-1];
      forced     = cnt_q == CW'(MAX_DIGITS - 1);
      close      = vld & (last | forced);
      state_d    = vld ? (close ? IDLE : BUSY) : state_q;
      carry_d    = vld ? (c & ~close) : carry_q;
      mode_d     = vld ? mode : mode_q;
      cnt_d      = vld ? (close ? '0 : cnt_q + CW'(1)) : cnt_q;
      out_vld_d  = vld;
      sum_d      = vld ? s : sum_q;
      out_last_d = close;
      out_cout_d = close & c;
      out_ovf_d  = close & (cm ^ c);
      len_err_d  = close & ~last;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         carry_q    <= 1'b0;
         mode_q     <= 1'b0;
         cnt_q      <= '0;
         out_vld_q  <= 1'b0;
         sum_q      <= '0;
         out_last_q <= 1'b0;
         out_cout_q <= 1'b0;
         out_ovf_q  <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         carry_q    <= carry_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         out_vld_q  <= out_vld_d;
         sum_q      <= sum_d;
         out_last_q <= out_last_d;
         out_cout_q <= out_cout_d;
         out_ovf_q  <= out_ovf_d;
         len_err_q  <= len_err_d;
      end
   end
   assign out_vld  = out_vld_q;
   assign sum      = sum_q;
   assign out_last = out_last_q;
   assign out_cout = out_cout_q;
   assign out_ovf  = out_ovf_q;
   assign len_err  = len_err_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: directed cases plus random words checked against whole-word integer arithmetic.
module tb_digit_serial_addsub;
   logic       clk = 1'b0, rst = 1'b1, vld = 1'b0, last = 1'b0, sub = 1'b0;
   logic [3:0] a = '0, b = '0, sum;
   logic       out_vld, out_last, out_cout, out_ovf, len_err;
   int         n_cmp = 0, n_bad = 0;
   logic [8:0] obs, exp_v;

   digit_serial_addsub #(.DIGIT_W(4), .MAX_DIGITS(4)) dut (
      .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .last(last), .sub(sub),
      .out_vld(out_vld), .sum(sum), .out_last(out_last), .out_cout(out_cout),
      .out_ovf(out_ovf), .len_err(len_err)
   );

   always #5 clk = ~clk;
   assign obs = {out_vld, out_last, out_cout, out_ovf, len_err, sum};

   task automatic step(input logic v, input logic [3:0] ia, input logic [3:0] ib, input logic il, input logic is);
      vld = v; a = ia; b = ib; last = il; sub = is;
      @(posedge clk);
      #1;
   endtask

   // whole-word reference: unsigned result/carry and signed overflow of n 4-bit digits
   function automatic void model(input int n, input logic [15:0] wa, input logic [15:0] wb, input logic s,
                                 output logic [15:0] r, output logic co, output logic ov);
      int     nb;
      longint m, ua, ub, t, sa, sb, sr, half;
      nb   = 4 * n;
      m    = (longint'(1) << nb) - 1;
      half = (m + 1) / 2;
      ua   = longint'(wa) & m;
      ub   = longint'(wb) & m;
      t    = s ? ua + (m + 1) - ub : ua + ub;
      r    = 16'(t & m);
      co   = t[nb];
      sa   = (ua >= half) ? ua - (m + 1) : ua;
      sb   = (ub >= half) ? ub - (m + 1) : ub;
      sr   = s ? sa - sb : sa + sb;
      ov   = (sr < -half) || (sr > half - 1);
   endfunction

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 9'h000) begin n_bad++; $display("FAIL reset_async: got %h want %h", obs, 9'h000); end
      step(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== 9'h000) begin n_bad++; $display("FAIL reset_held: got %h want %h", obs, 9'h000); end
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_add();
      step(1'b1, 4'h3, 4'h9, 1'b0, 1'b0);
      exp_v = {5'b10000, 4'hC};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL add_d0: got %h want %h", obs, exp_v); end
      step(1'b1, 4'h2, 4'h1, 1'b1, 1'b0);
      exp_v = {5'b11000, 4'h3};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL add_d1: got %h want %h", obs, exp_v); end
      step(1'b0, 4'h5, 4'h5, 1'b0, 1'b0);
      exp_v = {5'b00000, 4'h3};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL add_idle_hold: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_sub();
      step(1'b1, 4'h0, 4'h1, 1'b0, 1'b1);
      exp_v = {5'b10000, 4'hF};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL sub_d0: got %h want %h", obs, exp_v); end
      step(1'b1, 4'h3, 4'h0, 1'b1, 1'b0);
      exp_v = {5'b11100, 4'h2};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL sub_d1: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_single();
      step(1'b1, 4'h7, 4'h1, 1'b1, 1'b0);
      exp_v = {5'b11010, 4'h8};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL single_ovf: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_len_err();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
         exp_v = (i == 3) ? {5'b11001, 4'hF} : {5'b10000, 4'hF};
         n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL len_d%0d: got %h want %h", i, obs, exp_v); end
      end
      step(1'b1, 4'h1, 4'h1, 1'b1, 1'b0);
      exp_v = {5'b11000, 4'h2};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL len_next_word: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_gaps();
      step(1'b1, 4'h3, 4'h9, 1'b0, 1'b0);
      exp_v = {5'b10000, 4'hC};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL gap_d0: got %h want %h", obs, exp_v); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'(i), 4'hA, 1'b1, 1'b1);
         n_cmp++;
         if (obs !== exp_v[8:0] - 9'h100) begin n_bad++; $display("FAIL gap_idle%0d: got %h want %h", i, obs, exp_v - 9'h100); end
      end
      step(1'b1, 4'h2, 4'h1, 1'b1, 1'b0);
      exp_v = {5'b11000, 4'h3};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL gap_d1: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 4'h3, 4'h9, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 9'h000) begin n_bad++; $display("FAIL rmid_async: got %h want %h", obs, 9'h000); end
      vld = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== 9'h000) begin n_bad++; $display("FAIL rmid_held: got %h want %h", obs, 9'h000); end
      @(negedge clk) rst = 1'b1;
      step(1'b1, 4'h2, 4'h1, 1'b1, 1'b0);
      exp_v = {5'b11000, 4'h3};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL rmid_fresh: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_random();
      logic [15:0] wa, wb, r;
      logic        s0, co, ov, forced, fin;
      logic [3:0]  prev;
      int          n;
      step(1'b1, 4'h0, 4'h0, 1'b1, 1'b0);
      prev = 4'h0;
      for (int w = 0; w < 60; w++) begin
         n      = int'($urandom_range(1, 4));
         forced = (n == 4) && ($urandom_range(0, 2) == 0);
         wa     = 16'($urandom);
         wb     = 16'($urandom);
         s0     = 1'($urandom);
         model(n, wa, wb, s0, r, co, ov);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
               n_cmp++;
               if (obs !== {5'b00000, prev}) begin n_bad++; $display("FAIL rnd_gap w%0d: got %h want %h", w, obs, {5'b00000, prev}); end
            end
            fin = (i == n - 1);
            step(1'b1, wa[4*i +: 4], wb[4*i +: 4], fin && !forced, (i == 0) ? s0 : 1'($urandom));
            prev  = r[4*i +: 4];
            exp_v = {1'b1, fin, fin & co, fin & ov, fin & forced, prev};
            n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL rnd w%0d d%0d n%0d sub%0d: got %h want %h", w, i, n, s0, obs, exp_v); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_single();
      test_len_err();
      test_gaps();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
